// File: rtl/simon_ks_stream.sv
// Simon key schedule: loads an m-word master key and streams one round key
// per valid/ready handshake, with round index, busy flag and a done pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   1-cycle request: load key and (re)start the expansion
//   key        in   master key, word i = key[i*WORD_SIZE +: WORD_SIZE]
//   rkey       out  current round key (0 while idle)
//   rkey_valid out  rkey/rkey_idx hold a valid round key
//   rkey_ready in   consumer accepts rkey this cycle
//   rkey_idx   out  index of rkey, 0..NUM_ROUNDS-1 (0 while idle)
//   busy       out  expansion in progress
//   done       out  1-cycle pulse after the last round key is accepted
module simon_ks_stream #(
    parameter int WORD_SIZE  = 32,
    parameter int KEY_WORDS  = 4,
    parameter int NUM_ROUNDS = 44,
    parameter int Z_SEQ      = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [WORD_SIZE*KEY_WORDS-1:0]      key,
    output logic [WORD_SIZE-1:0]                rkey,
    output logic                                rkey_valid,
    input  logic                                rkey_ready,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]     rkey_idx,
    output logic                                busy,
    output logic                                done
);

    localparam int N     = WORD_SIZE;
    localparam int M     = KEY_WORDS;
    localparam int IDX_W = $clog2(NUM_ROUNDS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [N-1:0]     C_CONST  = ~N'(3);

    // Leftmost listed bit is sequence bit 0, i.e. literal bit 61.
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 =
        62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    localparam logic [61:0] Z_TAB =
        (Z_SEQ == 0) ? Z0 :
        (Z_SEQ == 1) ? Z1 :
        (Z_SEQ == 2) ? Z2 :
        (Z_SEQ == 3) ? Z3 : Z4;

    if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_m
        $error("simon_ks_stream: KEY_WORDS must be 2, 3 or 4");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 72) begin : g_bad_t
        $error("simon_ks_stream: NUM_ROUNDS must be 1..72");
    end
    if (Z_SEQ < 0 || Z_SEQ > 4) begin : g_bad_z
        $error("simon_ks_stream: Z_SEQ must be 0..4");
    end
    if (WORD_SIZE != 16 && WORD_SIZE != 24 && WORD_SIZE != 32 &&
        WORD_SIZE != 48 && WORD_SIZE != 64) begin : g_bad_n
        $error("simon_ks_stream: WORD_SIZE must be 16/24/32/48/64");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [M-1:0][N-1:0]   kreg, kreg_n;
    logic [IDX_W-1:0]      cnt, cnt_n;
    logic [5:0]            zidx, zidx_n;
    logic                  done_n;

    logic [N-1:0]          tmp_a;
    logic [N-1:0]          tmp_b;
    logic [N-1:0]          knew;
    logic                  zbit;

    function automatic logic [N-1:0] ror(input logic [N-1:0] x,
                                         input int j);
        return (x >> j) | (x << (N - j));
    endfunction

    // Next key word; kreg[0] is the oldest word (the key being output).
    always_comb begin
        tmp_a = ror(kreg[M-1], 3);
        if (M == 4) begin
            tmp_a = tmp_a ^ kreg[1];
        end
        tmp_b = tmp_a ^ ror(tmp_a, 1);
        zbit  = Z_TAB[6'd61 - zidx];
        knew  = kreg[0] ^ tmp_b ^ N'(zbit) ^ C_CONST;
    end

    always_comb begin
        state_n = state;
        kreg_n  = kreg;
        cnt_n   = cnt;
        zidx_n  = zidx;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    kreg_n  = key;
                    cnt_n   = '0;
                    zidx_n  = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // A restart wins over a same-cycle handshake.
                if (start) begin
                    kreg_n  = key;
                    cnt_n   = '0;
                    zidx_n  = '0;
                    state_n = RUN;
                end else if (rkey_ready) begin
                    kreg_n = {knew, kreg[M-1:1]};
                    cnt_n  = cnt + 1'b1;
                    zidx_n = (zidx == 6'd61) ? 6'd0 : zidx + 6'd1;
                    if (cnt == LAST_IDX) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kreg  <= '0;
            cnt   <= '0;
            zidx  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            kreg  <= kreg_n;
            cnt   <= cnt_n;
            zidx  <= zidx_n;
            done  <= done_n;
        end
    end

    always_comb begin
        rkey_valid = (state == RUN);
        busy       = (state == RUN);
        rkey       = rkey_valid ? kreg[0] : '0;
        rkey_idx   = rkey_valid ? cnt : '0;
    end

endmodule

// File: tb/tb_simon_ks_stream.sv
// Bench for simon_ks_stream: four configurations, golden key-expansion
// model feeding a scoreboard queue, directed steps in one initial block.
module tb_simon_ks_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rkey_ready = 1'b0;
    logic [3:0]   start = 4'b0;
    logic [255:0] mk = '0;

    always #5 clk = ~clk;

    logic [31:0] rk_a;
    logic        v_a, busy_a, done_a;
    logic [5:0]  idx_a;
    logic [15:0] rk_b;
    logic        v_b, busy_b, done_b;
    logic [5:0]  idx_b;
    logic [47:0] rk_c;
    logic        v_c, busy_c, done_c;
    logic [5:0]  idx_c;
    logic [63:0] rk_d;
    logic        v_d, busy_d, done_d;
    logic [6:0]  idx_d;

    simon_ks_stream #(.WORD_SIZE(32), .KEY_WORDS(4),
                      .NUM_ROUNDS(44), .Z_SEQ(3)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .key(mk[127:0]),
        .rkey(rk_a), .rkey_valid(v_a), .rkey_ready(rkey_ready),
        .rkey_idx(idx_a), .busy(busy_a), .done(done_a));

    simon_ks_stream #(.WORD_SIZE(16), .KEY_WORDS(4),
                      .NUM_ROUNDS(32), .Z_SEQ(0)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .key(mk[63:0]),
        .rkey(rk_b), .rkey_valid(v_b), .rkey_ready(rkey_ready),
        .rkey_idx(idx_b), .busy(busy_b), .done(done_b));

    simon_ks_stream #(.WORD_SIZE(48), .KEY_WORDS(2),
                      .NUM_ROUNDS(52), .Z_SEQ(2)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .key(mk[95:0]),
        .rkey(rk_c), .rkey_valid(v_c), .rkey_ready(rkey_ready),
        .rkey_idx(idx_c), .busy(busy_c), .done(done_c));

    simon_ks_stream #(.WORD_SIZE(64), .KEY_WORDS(4),
                      .NUM_ROUNDS(72), .Z_SEQ(4)) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .key(mk[255:0]),
        .rkey(rk_d), .rkey_valid(v_d), .rkey_ready(rkey_ready),
        .rkey_idx(idx_d), .busy(busy_d), .done(done_d));

    int          cur = 0;
    logic [63:0] obs_key;
    logic [6:0]  obs_idx;
    logic        obs_valid, obs_busy, obs_done;

    always_comb begin
        obs_key   = '0;
        obs_idx   = '0;
        obs_valid = 1'b0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        case (cur)
            0: begin
                obs_key = 64'(rk_a); obs_idx = 7'(idx_a);
                obs_valid = v_a; obs_busy = busy_a; obs_done = done_a;
            end
            1: begin
                obs_key = 64'(rk_b); obs_idx = 7'(idx_b);
                obs_valid = v_b; obs_busy = busy_b; obs_done = done_b;
            end
            2: begin
                obs_key = 64'(rk_c); obs_idx = 7'(idx_c);
                obs_valid = v_c; obs_busy = busy_c; obs_done = done_c;
            end
            default: begin
                obs_key = rk_d; obs_idx = idx_d;
                obs_valid = v_d; obs_busy = busy_d; obs_done = done_d;
            end
        endcase
    end

    typedef struct {
        int          idx;
        logic [63:0] key;
    } exp_t;

    exp_t        q[$];
    logic [61:0] ztab [5];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int j,
                                        input int n, input logic [63:0] mask);
        return ((x >> j) | (x << (n - j))) & mask;
    endfunction

    // Golden expansion: k[i+m] = k[i] ^ f(k[i+m-1], k[i+1]) ^ z[i mod 62] ^ c
    task automatic model(input int n, input int m, input int t,
                         input int zs);
        logic [63:0] w [80];
        logic [63:0] mask, c, tmp;
        logic        zb;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        c = mask & ~64'd3;
        q.delete();
        for (int i = 0; i < m; i++) begin
            w[i] = 64'(mk >> (i * n)) & mask;
        end
        for (int i = 0; i + m < t; i++) begin
            tmp = rot(w[i+m-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ w[i+1];
            tmp = tmp ^ rot(tmp, 1, n, mask);
            zb = ztab[zs][61 - (i % 62)];
            w[i+m] = w[i] ^ tmp ^ c ^ 64'(zb);
        end
        for (int i = 0; i < t; i++) begin
            q.push_back('{idx: i, key: w[i]});
        end
    endtask

    task automatic kick(input int s);
        @(negedge clk);
        start[s] = 1'b1;
        @(posedge clk);
        #1 start[s] = 1'b0;
    endtask

    // Consume keys from the selected instance; stop early when the expected
    // index equals stop (ready left untouched), else run to the done pulse.
    task automatic drain(input int t, input bit rnd, input int stop);
        logic [63:0] last_key = '0;
        bit          stalled = 1'b0;
        bit          exp_done = 1'b0;
        int          got = 0;
        logic        rdy;
        for (int cyc = 0; cyc < t * 8 + 50; cyc++) begin
            @(negedge clk);
            chk("done", 64'(obs_done), 64'(exp_done));
            if (exp_done) begin
                chk("end_valid", 64'(obs_valid), 64'd0);
                chk("end_busy", 64'(obs_busy), 64'd0);
                return;
            end
            chk("valid", 64'(obs_valid), 64'd1);
            chk("busy", 64'(obs_busy), 64'd1);
            chk("idx", 64'(obs_idx), 64'(q[0].idx));
            chk("rkey", obs_key, q[0].key);
            if (stalled) chk("stable", obs_key, last_key);
            if (stop >= 0 && q[0].idx == stop) return;
            rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            rkey_ready = rdy;
            if (rdy) begin
                void'(q.pop_front());
                got++;
                stalled = 1'b0;
                if (got == t) exp_done = 1'b1;
            end else begin
                stalled = 1'b1;
                last_key = obs_key;
            end
        end
        chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(obs_valid), 64'd0);
        chk({tag, "_busy"}, 64'(obs_busy), 64'd0);
        chk({tag, "_done"}, 64'(obs_done), 64'd0);
        chk({tag, "_rkey"}, obs_key, 64'd0);
        chk({tag, "_idx"}, 64'(obs_idx), 64'd0);
    endtask

    localparam logic [127:0] K64 = 128'h1b1a1918_13121110_0b0a0908_03020100;

    initial begin
        ztab[0] = 62'b11111010001001010110000111001101111101000100101011000011100110;
        ztab[1] = 62'b10001110111110010011000010110101000111011111001001100001011010;
        ztab[2] = 62'b10101111011100000011010010011000101000010001111110010110110011;
        ztab[3] = 62'b11011011101011000110010111100000010010001010011100110100001111;
        ztab[4] = 62'b11010001111001101011011000100000010111000011001010010011101111;

        // Power-up reset and idle behaviour.
        cur = 0;
        #1 rst = 1'b1;
        #12 chk_zero("por");
        @(negedge clk) rst = 1'b0;
        rkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("idle");

        // Simon64/128 reference key, ready held high.
        mk = {128'h0, K64};
        model(32, 4, 44, 3);
        chk("vec_k0", q[0].key, 64'h03020100);
        chk("vec_k3", q[3].key, 64'h1b1a1918);
        kick(0);
        drain(44, 1'b0, -1);

        // Same key under random backpressure.
        model(32, 4, 44, 3);
        kick(0);
        drain(44, 1'b1, -1);

        // n=16 m=4 z0 and n=48 m=2 z2.
        for (int i = 0; i < 8; i++) mk[i*32 +: 32] = $urandom;
        cur = 1;
        model(16, 4, 32, 0);
        kick(1);
        drain(32, 1'b1, -1);
        cur = 2;
        model(48, 2, 52, 2);
        kick(2);
        drain(52, 1'b0, -1);

        // n=64 m=4 z4 T=72: z index wraps.
        for (int i = 0; i < 8; i++) mk[i*32 +: 32] = $urandom;
        cur = 3;
        model(64, 4, 72, 4);
        kick(3);
        drain(72, 1'b1, -1);

        // Restart at idx 7 with ready high; no done from the aborted run.
        cur = 0;
        mk = {128'h0, K64};
        model(32, 4, 44, 3);
        rkey_ready = 1'b1;
        kick(0);
        drain(44, 1'b0, 7);
        mk = {128'h0, 128'h0f0e0d0c_8899aabb_deadbeef_cafef00d};
        model(32, 4, 44, 3);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        drain(44, 1'b0, -1);

        // Asynchronous reset at idx 10.
        mk = {128'h0, K64};
        model(32, 4, 44, 3);
        kick(0);
        drain(44, 1'b0, 10);
        #2 rst = 1'b1;
        #1 chk_zero("arst");
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_zero("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
